count_display_scanner: RTL and testbench
========================================

Name: count_display_scanner

Overview:
- Downstream consumer of the 4-bit up/down alternating counter.
- Samples the counter's count output and keeps a 4-deep history of distinct values.
- Classifies each step as up, down or jump.
- Time-multiplexes the history onto a 4-digit common-anode seven-segment display: active-low anodes, segments and decimal point.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot; at 100 MHz this gives a 1 kHz digit rate. Legal range 2..2^20. Benches use 4.
CNT_W, 20, width of the refresh divider; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
Clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
en  input  1  sample strobe; same enable that drives the counter.
count  input  4  counter value to display.
an  output  4  digit anodes, active-low, one-hot when lit. an[0] is the rightmost digit.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
dir  output  2  class of the last captured step: 00 none, 01 up, 10 down, 11 jump.
new_val  output  1  one-cycle pulse, the cycle after a capture.

Behaviour:
- Reset applies immediately on assertion, independent of Clk. It clears all of the following:
  - hist[0..3]=0, last=0, valid=0, dir=00, new_val=0;
  - divider=0, digit_idx=0, lit=0;
  - an=4'b1111, seg=7'b1111111, dp=1 (display blank).
- Capture rule: a capture occurs at a rising edge where en=1 AND (valid=0 OR count != last).
- On capture:
  - hist shifts: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0], hist[0]<=count;
  - last<=count, valid<=1;
  - new_val=1 in the next cycle only.
- en=1 with count==last and valid=1: no capture, no shift, dir unchanged.
- en=0: count is ignored entirely.
- Direction, computed at capture from delta=(count-last) mod 16 using 4-bit wrap arithmetic:
  - valid=0 -> 00;
  - delta=1 -> 01 (15->0 counts as up);
  - delta=15 -> 10 (0->15 counts as down);
  - any other delta -> 11.
- dir is registered; it updates in the same edge as hist.
- Refresh divider:
  - counts 0..REFRESH_DIV-1 and wraps to 0; the terminal count produces tick;
  - on tick: if lit=0, lit<=1 and digit_idx stays 0; otherwise digit_idx<=digit_idx+1 mod 4 (3 wraps to 0).
  - The first lit digit therefore appears REFRESH_DIV cycles after reset release.
- Output registers, updated every cycle from the current digit_idx:
  - an = ~(1<<digit_idx) when lit, else 4'b1111;
  - seg = hex7(hist[digit_idx]), hex digits 0-F;
  - dp = 0 only when digit_idx=0 AND dir=10 (down), else 1.
- Digit-to-history mapping: digit 0 shows the newest value, digit 3 the oldest.
- Latency: one cycle from a register change to the pins.
- Simultaneous capture and tick: both take effect. The digit driven after that edge shows the updated hist.
- Reset mid-scan: display blanks immediately; the scan restarts at digit 0 after a full REFRESH_DIV.
- Undefined (X) count while en=1 is not a supported condition; no X-pessimism handling is required.

Decomposition:
- Shared package seg7_pkg holds:
  - active-low constants SEG_BLANK=7'h7F and AN_OFF=4'hF;
  - dir encodings DIR_NONE, DIR_UP, DIR_DOWN, DIR_JUMP;
  - the 16-entry hex-to-segment table.
- One natural sub-module: hex_to_seg7, combinational 4-bit -> 7-bit active-low decoder. It is instantiated once on the muxed history digit.
- Capture/direction logic and scan logic live in the top as two always blocks.

Test Plan:
1. Reset, REFRESH_DIV=4:
   - hold reset, then release -> an=1111, seg=7F, dp=1 for 4 cycles;
   - then an=1110, seg=7'h40 (digit "0").
2. Capture up:
   - en=1, count 0,1,2,3 on successive cycles;
   - hist={3,2,1,0} with digit 0 newest, dir=01, new_val pulses 4 times;
   - scan shows an=1110 seg=7'h30 ("3"), then an=1101 seg=7'h24 ("2").
3. Wrap up:
   - last=15, count=0 with en=1 -> dir=01, hist[0]=0.
   - Wrap down: last=0, count=15 -> dir=10, and dp=0 while an=1110.
4. Hold and jump:
   - en=1 with count held at 5 for 10 cycles -> exactly one capture, one new_val;
   - then count=9 -> dir=11, hist[0]=9.
5. Gating: en=0 while count toggles 1..8 -> no capture, hist unchanged, new_val=0.
6. Async reset mid-scan:
   - assert reset for 2 ns between edges while an=1011;
   - an=1111, seg=7F, dp=1 immediately with no clock edge; hist cleared;
   - after release, digit 0 lights after 4 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the count display scanner: active-low display constants,
// step-direction encodings and the hex-to-seven-segment table.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10,
        DIR_JUMP = 2'b11
    } dir_t;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is leftmost, entry 0 rightmost.
    localparam logic [15:0][6:0] SEG_TABLE = '{
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex digit to active-low seven-segment pattern.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/count_display_scanner.sv
// Captures distinct counter values into a 4-deep history, classifies each step,
// and scans the history onto a 4-digit common-anode seven-segment display.
module count_display_scanner
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int CNT_W       = 20
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] count,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] dir,
    output logic       new_val
);

    logic [3:0][3:0] hist;
    logic [3:0]      last;
    logic            valid;
    dir_t            dir_q;
    dir_t            next_dir;
    logic [3:0]      delta;
    logic            capture;

    logic [CNT_W-1:0] divider;
    logic [1:0]       digit_idx;
    logic             lit;
    logic             tick;
    logic [3:0]       cur_digit;
    logic [6:0]       seg_dec;

    assign capture = en && (!valid || count != last);
    assign delta   = count - last;

    // NOTE: every variable gets a default before the ifs, so no latch is inferred.
    always_comb begin
        next_dir = DIR_JUMP;
        if (!valid)
            next_dir = DIR_NONE;
        else if (delta == 4'd1)
            next_dir = DIR_UP;
        else if (delta == 4'd15)
            next_dir = DIR_DOWN;
    end

    // NOTE: the history is a handful of flops, not a RAM, so it is cleared by reset.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            hist    <= '0;
            last    <= '0;
            valid   <= 1'b0;
            dir_q   <= DIR_NONE;
            new_val <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            new_val <= capture;
            if (capture) begin
                hist  <= {hist[2:0], count};
                last  <= count;
                valid <= 1'b1;
                dir_q <= next_dir;
            end
        end
    end

    assign dir = dir_q;

    assign tick      = (divider == CNT_W'(REFRESH_DIV - 1));
    assign cur_digit = hist[digit_idx];

    hex_to_seg7 u_hex_to_seg7 (
        .digit (cur_digit),
        .seg   (seg_dec)
    );

    // The first tick after reset only lights digit 0; later ticks advance the scan.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            divider   <= '0;
            digit_idx <= '0;
            lit       <= 1'b0;
            an        <= AN_OFF;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            divider <= tick ? '0 : divider + CNT_W'(1);
            if (tick) begin
                if (!lit)
                    lit <= 1'b1;
                else
                    digit_idx <= digit_idx + 2'd1;
            end
            an  <= lit ? ~(4'b0001 << digit_idx) : AN_OFF;
            seg <= lit ? seg_dec : SEG_BLANK;
            dp  <= !(lit && digit_idx == 2'd0 && dir_q == DIR_DOWN);
        end
    end

endmodule

// File: tb/tb_count_display_scanner.sv
// Scoreboarded bench: capture directions are queued at stimulus time and checked
// by a monitor on each new_val pulse; display contents are checked per digit.
module tb_count_display_scanner;

    localparam logic [1:0] D_NONE = 2'b00;
    localparam logic [1:0] D_UP   = 2'b01;
    localparam logic [1:0] D_DOWN = 2'b10;
    localparam logic [1:0] D_JUMP = 2'b11;

    logic       Clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dir;
    logic       new_val;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_q[$];

    count_display_scanner #(.REFRESH_DIV(4), .CNT_W(20)) dut (
        .Clk     (Clk),
        .reset   (reset),
        .en      (en),
        .count   (count),
        .an      (an),
        .seg     (seg),
        .dp      (dp),
        .dir     (dir),
        .new_val (new_val)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: each new_val pulse must match the oldest queued direction.
    initial begin
        forever begin
            @(negedge Clk);
            if (new_val === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_new_val: got pulse with dir %0b, expected no capture", dir);
                end else begin
                    check("capture_dir", 32'(dir), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic drive(input logic [3:0] c, input logic [1:0] d);
        en    = 1'b1;
        count = c;
        exp_q.push_back(d);
        @(negedge Clk);
    endtask

    task automatic idle();
        en = 1'b0;
        @(negedge Clk);
    endtask

    task automatic blank_then_lit(input string name);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            check({name, "_blank"}, 32'({an, seg, dp}), 32'({4'hF, 7'h7F, 1'b1}));
        end
        @(negedge Clk);
        check({name, "_first_lit"}, 32'({an, seg, dp}), 32'({4'b1110, 7'h40, 1'b1}));
    endtask

    task automatic show_digit(input int d, input logic [6:0] s, input logic p, input string name);
        logic [3:0] want;
        bit found;
        want  = ~(4'b0001 << d);
        found = 0;
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 40 && !found; i++) begin
            if (an === want) found = 1;
            else @(negedge Clk);
        end
        if (!found) begin
            n_checks++;
            $display("FAIL %s_timeout: anode %0b never seen, last an %0b", name, want, an);
        end else begin
            check(name, 32'({seg, dp}), 32'({s, p}));
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1;
        en    = 1'b0;
        count = 4'd0;
        repeat (3) @(negedge Clk);
        check("reset_outputs", 32'({an, seg, dp, dir, new_val}), 32'({4'hF, 7'h7F, 1'b1, 2'b00, 1'b0}));
        reset = 1'b0;

        // 1. Reset release: blank for four cycles, then digit 0 shows "0".
        blank_then_lit("reset");

        // 2. Count up 0..3.
        drive(4'd0, D_NONE);
        drive(4'd1, D_UP);
        drive(4'd2, D_UP);
        drive(4'd3, D_UP);
        idle();
        check("up_dir", 32'(dir), 32'(D_UP));
        show_digit(0, 7'h30, 1'b1, "up_d0");
        show_digit(1, 7'h24, 1'b1, "up_d1");
        show_digit(2, 7'h79, 1'b1, "up_d2");
        show_digit(3, 7'h40, 1'b1, "up_d3");

        // 3. Wrap up 15->0, then wrap down 0->15 (dp lit on digit 0).
        drive(4'd15, D_JUMP);
        drive(4'd0, D_UP);
        idle();
        show_digit(0, 7'h40, 1'b1, "wrap_up_d0");
        show_digit(1, 7'h0E, 1'b1, "wrap_up_d1");
        drive(4'd15, D_DOWN);
        idle();
        show_digit(0, 7'h0E, 1'b0, "wrap_down_d0_dp");
        show_digit(1, 7'h40, 1'b1, "wrap_down_d1");

        // 4. Hold 5 for ten cycles (single capture), then jump to 9.
        en    = 1'b1;
        count = 4'd5;
        exp_q.push_back(D_JUMP);
        repeat (10) @(negedge Clk);
        drive(4'd9, D_JUMP);
        idle();
        show_digit(0, 7'h10, 1'b1, "jump_d0");
        show_digit(1, 7'h12, 1'b1, "jump_d1");

        // 5. en low: toggling count must not disturb anything.
        en = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            count = 4'(i);
            @(negedge Clk);
        end
        show_digit(0, 7'h10, 1'b1, "gate_d0");
        show_digit(1, 7'h12, 1'b1, "gate_d1");
        show_digit(2, 7'h0E, 1'b1, "gate_d2");
        show_digit(3, 7'h40, 1'b1, "gate_d3");

        // 6. Asynchronous reset while digit 2 is lit.
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (an === 4'b1011) found = 1;
            else @(negedge Clk);
        end
        if (!found) begin
            n_checks++;
            $display("FAIL midscan_wait: an 1011 never seen, last an %0b", an);
        end
        #1 reset = 1'b1;
        #1 check("async_reset_blank", 32'({an, seg, dp, dir, new_val}), 32'({4'hF, 7'h7F, 1'b1, 2'b00, 1'b0}));
        #1 reset = 1'b0;
        blank_then_lit("midscan");
        show_digit(1, 7'h40, 1'b1, "midscan_hist1_cleared");
        show_digit(3, 7'h40, 1'b1, "midscan_hist3_cleared");

        // First capture after reset has no predecessor.
        drive(4'd7, D_NONE);
        idle();
        show_digit(0, 7'h78, 1'b1, "post_reset_d0");

        repeat (4) @(negedge Clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
